// File: rtl/encoder_controller.sv
// Sequencing FSM for the encoder datapath: launches the five step modules in
// order each round, then advances the round/file counters until the run completes.
module encoder_controller #(
  parameter int NUM_FILES  = 64,
  parameter int NUM_ROUNDS = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       CP_finish,
  input  logic       RO_finish,
  input  logic       PE_finish,
  input  logic       RV_finish,
  input  logic       RC_finish,
  output logic       CP_start,
  output logic       RO_start,
  output logic       PE_start,
  output logic       RV_start,
  output logic       RC_start,
  output logic [9:0] file_index,
  output logic [4:0] iteration,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE, CP_GO, CP_WAIT, RO_GO, RO_WAIT, PE_GO, PE_WAIT,
    RV_GO, RV_WAIT, RC_GO, RC_WAIT, NEXT, DONE
  } state_t;

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);
  localparam logic [9:0] LAST_FILE  = 10'(NUM_FILES - 1);

  state_t     state, state_next;
  logic [9:0] file_next;
  logic [4:0] iter_next;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      file_index <= '0;
      iteration  <= '0;
    end else begin
      state      <= state_next;
      file_index <= file_next;
      iteration  <= iter_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    file_next  = file_index;
    iter_next  = iteration;
    CP_start   = 1'b0;
    RO_start   = 1'b0;
    PE_start   = 1'b0;
    RV_start   = 1'b0;
    RC_start   = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);

    case (state)
      IDLE: begin
        if (start) begin
          file_next  = '0;
          iter_next  = '0;
          state_next = CP_GO;
        end
      end
      CP_GO: begin
        CP_start   = 1'b1;
        state_next = CP_WAIT;
      end
      CP_WAIT: if (CP_finish) state_next = RO_GO;
      RO_GO: begin
        RO_start   = 1'b1;
        state_next = RO_WAIT;
      end
      RO_WAIT: if (RO_finish) state_next = PE_GO;
      PE_GO: begin
        PE_start   = 1'b1;
        state_next = PE_WAIT;
      end
      PE_WAIT: if (PE_finish) state_next = RV_GO;
      RV_GO: begin
        RV_start   = 1'b1;
        state_next = RV_WAIT;
      end
      RV_WAIT: if (RV_finish) state_next = RC_GO;
      RC_GO: begin
        RC_start   = 1'b1;
        state_next = RC_WAIT;
      end
      RC_WAIT: if (RC_finish) state_next = NEXT;
      NEXT: begin
        // Counters move only here, so they are stable across a whole round.
        if (iteration < LAST_ROUND) begin
          iter_next  = iteration + 5'd1;
          state_next = CP_GO;
        end else if (file_index < LAST_FILE) begin
          iter_next  = '0;
          file_next  = file_index + 10'd1;
          state_next = CP_GO;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
